// File: rtl/debouncer.sv
// Per-bit debouncer for already-synchronized inputs: a shared free-running
// sample tick feeds saturating per-bit "stable-high" counters.
module debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PW = (PULSE_CNT_MAX > 1) ? $clog2(PULSE_CNT_MAX + 1) : 1;

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PULSE_TOP   = PW'(PULSE_CNT_MAX);

  logic [SW-1:0]    r_sample_cnt;
  logic             w_sample_tick;
  logic [PW-1:0]    r_pulse_cnt [WIDTH];
  logic [WIDTH-1:0] w_debounced;
  logic [WIDTH-1:0] r_debounced_d;
  logic [WIDTH-1:0] r_rising_pulse;

  assign w_sample_tick = (r_sample_cnt == SAMPLE_LAST);

  // Free-running tick source shared by every bit; input activity never restarts it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_cnt <= '0;
    end else if (w_sample_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  // A low sample on any cycle clears the run; ticks only advance it up to saturation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst || !glitchy_signal[i]) begin
        r_pulse_cnt[i] <= '0;
      end else if (w_sample_tick && (r_pulse_cnt[i] < PULSE_TOP)) begin
        r_pulse_cnt[i] <= r_pulse_cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_debounced = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_debounced[i] = (r_pulse_cnt[i] == PULSE_TOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_debounced_d  <= '0;
      r_rising_pulse <= '0;
    end else begin
      r_debounced_d  <= w_debounced;
      r_rising_pulse <= w_debounced & ~r_debounced_d;
    end
  end

  assign debounced_signal = w_debounced;
  assign rising_pulse     = r_rising_pulse;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: per-cycle comparison against a tick-counting
// reference model, plus directed checks with hand-derived edge numbers.
module tb_debouncer;

  localparam int W = 2;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] glitchy_signal = '0;
  logic [W-1:0] debounced_signal;
  logic [W-1:0] rising_pulse;

  int checks = 0;
  int errors = 0;

  debouncer #(
    .WIDTH         (W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX (P)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .glitchy_signal  (glitchy_signal),
    .debounced_signal(debounced_signal),
    .rising_pulse    (rising_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a bit is pressed once it has been high across at least P
  // sample ticks since it was last seen low; ticks fall every S-th edge after reset.
  int           edges_since_rst = 0;
  int           ticks_high [W];
  logic [W-1:0] m_deb      = '0;
  logic [W-1:0] m_deb_hist = '0;
  logic [W-1:0] m_pulse    = '0;
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] deb_before;
    bit           tick;
    deb_before = m_deb;
    if (rst) begin
      edges_since_rst = 0;
      for (int i = 0; i < W; i++) ticks_high[i] = 0;
      m_deb       = '0;
      m_deb_hist  = '0;
      m_pulse     = '0;
      model_valid = 1'b1;
    end else begin
      tick = ((edges_since_rst % S) == S - 1);
      edges_since_rst++;
      for (int i = 0; i < W; i++) begin
        if (!glitchy_signal[i]) ticks_high[i] = 0;
        else if (tick)          ticks_high[i] = ticks_high[i] + 1;
        m_deb[i] = (ticks_high[i] >= P);
      end
      // Pulse shows one cycle after the level went 0 -> 1.
      m_pulse    = deb_before & ~m_deb_hist;
      m_deb_hist = deb_before;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model debounced_signal", 32'(debounced_signal), 32'(m_deb));
      check("model rising_pulse",     32'(rising_pulse),     32'(m_pulse));
    end
  end

  int pulse_count [W];

  // Advance one clock edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < W; i++) if (rising_pulse[i] === 1'b1) pulse_count[i]++;
  endtask

  task automatic do_reset();
    glitchy_signal = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++) pulse_count[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < W; i++) pulse_count[i] = 0;

    // Reset state.
    do_reset();
    check("reset debounced", 32'(debounced_signal), 32'h0);
    check("reset pulse",     32'(rising_pulse),     32'h0);

    // Press bit 0, release at edge 20, re-press from edge 21.
    for (int e = 0; e <= 33; e++) begin
      glitchy_signal = (e == 20) ? 2'b00 : 2'b01;
      step();
      case (e)
        10: check("press deb before edge 11", 32'(debounced_signal), 32'h0);
        11: begin
          check("press deb at edge 11",   32'(debounced_signal), 32'h1);
          check("press pulse at edge 11", 32'(rising_pulse),     32'h0);
        end
        12: check("press pulse at edge 12", 32'(rising_pulse), 32'h1);
        13: check("press pulse at edge 13", 32'(rising_pulse), 32'h0);
        20: begin
          check("release deb at edge 20",   32'(debounced_signal), 32'h0);
          check("release pulse at edge 20", 32'(rising_pulse),     32'h0);
        end
        30: check("repress deb at edge 30",   32'(debounced_signal), 32'h0);
        31: check("repress deb at edge 31",   32'(debounced_signal), 32'h1);
        32: check("repress pulse at edge 32", 32'(rising_pulse),     32'h1);
        default: ;
      endcase
    end
    check("press+repress pulse count bit0", 32'(pulse_count[0]), 32'd2);
    check("press+repress pulse count bit1", 32'(pulse_count[1]), 32'd0);

    // Bounce: low only at edge 6 restarts the count.
    do_reset();
    for (int e = 0; e <= 17; e++) begin
      glitchy_signal = (e == 6) ? 2'b00 : 2'b01;
      step();
      if (e == 14) check("bounce deb at edge 14",   32'(debounced_signal), 32'h0);
      if (e == 15) check("bounce deb at edge 15",   32'(debounced_signal), 32'h1);
      if (e == 16) check("bounce pulse at edge 16", 32'(rising_pulse),     32'h1);
    end
    check("bounce pulse count", 32'(pulse_count[0]), 32'd1);

    // Long hold yields exactly one pulse and the level stays up.
    do_reset();
    glitchy_signal = 2'b01;
    for (int e = 0; e < 200; e++) step();
    check("hold pulse count", 32'(pulse_count[0]), 32'd1);
    check("hold deb at end",  32'(debounced_signal), 32'h1);

    // Both bits together.
    do_reset();
    glitchy_signal = 2'b11;
    for (int e = 0; e <= 13; e++) begin
      step();
      if (e == 11) check("both deb at edge 11",   32'(debounced_signal), 32'h3);
      if (e == 12) check("both pulse at edge 12", 32'(rising_pulse),     32'h3);
      if (e == 13) check("both pulse at edge 13", 32'(rising_pulse),     32'h0);
    end

    // Reset mid-press at edge 9; sample phase restarts afterwards.
    do_reset();
    glitchy_signal = 2'b01;
    for (int e = 0; e <= 8; e++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset deb after reset",   32'(debounced_signal), 32'h0);
    check("midreset pulse after reset", 32'(rising_pulse),     32'h0);
    for (int e = 0; e <= 12; e++) begin
      step();
      if (e == 10) check("midreset deb at new edge 10",   32'(debounced_signal), 32'h0);
      if (e == 11) check("midreset deb at new edge 11",   32'(debounced_signal), 32'h1);
      if (e == 11) check("midreset pulse at new edge 11", 32'(rising_pulse),     32'h0);
      if (e == 12) check("midreset pulse at new edge 12", 32'(rising_pulse),     32'h1);
    end
    check("midreset pulse count", 32'(pulse_count[0]), 32'd1);

    // Random bouncy traffic with occasional resets; the model compares every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 15) == 0) glitchy_signal[i] = ~glitchy_signal[i];
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
